cdr_link_supervisor: RTL and testbench

Sequences bring-up and recovery of the 4x-oversampling CDR on the 200 MHz link clock. It holds the CDR in reset and releases it, waits for lock, then hunts for a 16-bit sync word in the recovered bitstream before declaring the link up. It retrains with bounded retries and backoff on any lock loss or timeout, and latches a fault after too many consecutive failures. It sits between the link-management registers and the CDR instance, and its `link_up` gates the downstream deframer.

---
 rtl/cdr_link_pkg.sv | 28 ++
 rtl/cdr_link_supervisor_if.sv | 28 ++
 rtl/link_sync_detect.sv | 44 ++++
 rtl/cdr_link_supervisor.sv | 137 +++++++++++++
 tb/tb_cdr_link_supervisor.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdr_link_pkg.sv
// Shared definitions for the CDR link supervisor.
// Holds the supervisor state encoding (also exported on the debug `state` port),
// the default frame sync word, the link-drop counter width and a small helper
// used to size the shared timer.
package cdr_link_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StCdrReset = 3'd1,
        StWaitLock = 3'd2,
        StHuntSync = 3'd3,
        StLinkUp   = 3'd4,
        StBackoff  = 3'd5,
        StFault    = 3'd6
    } link_state_e;

    localparam logic [15:0] SyncWordDefault = 16'hA5C3;
    localparam int unsigned LinkDropsWidth  = 8;
    localparam int unsigned RetryWidth      = 4;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cdr_link_supervisor_if.sv
// Supervisor <-> CDR connection.
//   cdr_rst_n     : synchronous active-low reset driven to the CDR
//   cdr_locked    : CDR lock status
//   cdr_bit       : recovered bit
//   cdr_bit_valid : recovered-bit strobe
// master = supervisor side, slave = CDR side.
interface cdr_link_supervisor_if;

    logic cdr_rst_n;
    logic cdr_locked;
    logic cdr_bit;
    logic cdr_bit_valid;

    modport master (
        output cdr_rst_n,
        input  cdr_locked,
        input  cdr_bit,
        input  cdr_bit_valid
    );

    modport slave (
        input  cdr_rst_n,
        output cdr_locked,
        output cdr_bit,
        output cdr_bit_valid
    );

endinterface

// File: rtl/link_sync_detect.sv
// Sync-word hunter: 16-bit shift register, match logic and valid-bit counter.
//   clk_link, rst_n : clock, synchronous active-low reset
//   clear           : holds the shift register and bit counter at zero
//   data_bit, valid : recovered bit and its strobe
//   match           : this valid bit completes SYNC_WORD (post-shift compare)
//   timeout         : this valid bit is number SYNC_TIMEOUT_BITS and did not match
module link_sync_detect
    import cdr_link_pkg::*;
#(
    parameter logic [15:0] SYNC_WORD         = SyncWordDefault,
    parameter int unsigned SYNC_TIMEOUT_BITS = 1024
) (
    input  logic clk_link,
    input  logic rst_n,
    input  logic clear,
    input  logic data_bit,
    input  logic valid,
    output logic match,
    output logic timeout
);

    localparam int unsigned CntWidth = $clog2(SYNC_TIMEOUT_BITS + 1);

    logic [15:0]         sr_q;
    logic [15:0]         sr_next;
    logic [CntWidth-1:0] cnt_q;

    assign sr_next = {sr_q[14:0], data_bit};
    assign match   = valid && (sr_next == SYNC_WORD);
    assign timeout = valid && !match && (cnt_q == CntWidth'(SYNC_TIMEOUT_BITS - 1));

    always_ff @(posedge clk_link) begin
        if (!rst_n || clear) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (valid) begin
            sr_q <= sr_next;
            if (cnt_q != '1) begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/cdr_link_supervisor.sv
// CDR bring-up / recovery supervisor.
// Resets the CDR, waits for lock, hunts the sync word, then reports link up.
// Failures (lock timeout, sync timeout, lock loss) back off and retry; after
// MAX_RETRIES consecutive failures the supervisor parks in FAULT.
//   clk_link, rst_n : link clock, synchronous active-low reset
//   enable          : level-sensitive link enable
//   clear_fault     : pulse that leaves FAULT
//   cdr             : CDR-side interface (master modport)
//   link_up, fault  : registered status
//   link_drops      : saturating count of lock losses while up
//   state           : current state, for debug
module cdr_link_supervisor
    import cdr_link_pkg::*;
#(
    parameter int unsigned RST_CYCLES        = 16,
    parameter int unsigned LOCK_TIMEOUT      = 4096,
    parameter logic [15:0] SYNC_WORD         = SyncWordDefault,
    parameter int unsigned SYNC_TIMEOUT_BITS = 1024,
    parameter int unsigned BACKOFF_CYCLES    = 256,
    parameter int unsigned MAX_RETRIES       = 4
) (
    input  logic                      clk_link,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      clear_fault,
    cdr_link_supervisor_if.master     cdr,
    output logic                      link_up,
    output logic                      fault,
    output logic [LinkDropsWidth-1:0] link_drops,
    output logic [2:0]                state
);

    localparam int unsigned TimerMax   = max3(RST_CYCLES, LOCK_TIMEOUT, BACKOFF_CYCLES);
    localparam int unsigned TimerWidth = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    link_state_e               state_q, state_d;
    logic [TimerWidth-1:0]     timer_q;
    logic [RetryWidth-1:0]     retry_q, retry_inc;
    logic [LinkDropsWidth-1:0] drops_q;
    logic                      cdr_rst_n_q, link_up_q, fault_q;
    logic                      fail;
    logic                      sync_match, sync_timeout;

    link_sync_detect #(
        .SYNC_WORD         (SYNC_WORD),
        .SYNC_TIMEOUT_BITS (SYNC_TIMEOUT_BITS)
    ) u_sync (
        .clk_link (clk_link),
        .rst_n    (rst_n),
        .clear    (state_q != StHuntSync),
        .data_bit (cdr.cdr_bit),
        .valid    (cdr.cdr_bit_valid),
        .match    (sync_match),
        .timeout  (sync_timeout)
    );

    assign retry_inc = retry_q + RetryWidth'(1);

    always_comb begin
        state_d = state_q;
        fail    = 1'b0;
        case (state_q)
            StIdle:     if (enable) state_d = StCdrReset;
            StCdrReset: if (timer_q == TimerWidth'(RST_CYCLES - 1)) state_d = StWaitLock;
            StWaitLock: begin
                if (cdr.cdr_locked) begin
                    state_d = StHuntSync;
                end else if (timer_q == TimerWidth'(LOCK_TIMEOUT - 1)) begin
                    fail = 1'b1;
                end
            end
            // Lock loss beats a same-cycle sync match.
            StHuntSync: begin
                if (!cdr.cdr_locked || sync_timeout) begin
                    fail = 1'b1;
                end else if (sync_match) begin
                    state_d = StLinkUp;
                end
            end
            StLinkUp:   if (!cdr.cdr_locked) fail = 1'b1;
            StBackoff:  if (timer_q == TimerWidth'(BACKOFF_CYCLES - 1)) state_d = StCdrReset;
            StFault:    if (clear_fault) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
        if (fail) begin
            state_d = (retry_inc == RetryWidth'(MAX_RETRIES)) ? StFault : StBackoff;
        end
        // Disable overrides everything, including a pending failure.
        if (!enable) begin
            state_d = StIdle;
            fail    = 1'b0;
        end
    end

    always_ff @(posedge clk_link) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            retry_q     <= '0;
            drops_q     <= '0;
            cdr_rst_n_q <= 1'b0;
            link_up_q   <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                timer_q <= '0;
            end else if (timer_q != '1) begin
                timer_q <= timer_q + TimerWidth'(1);
            end

            if (!enable || (state_q == StFault && state_d == StIdle) ||
                (state_d == StLinkUp && state_q != StLinkUp)) begin
                retry_q <= '0;
            end else if (fail) begin
                retry_q <= retry_inc;
            end

            if (fail && state_q == StLinkUp && drops_q != '1) begin
                drops_q <= drops_q + LinkDropsWidth'(1);
            end

            // Outputs follow the next state so they change with the state register.
            cdr_rst_n_q <= (state_d == StWaitLock) || (state_d == StHuntSync) ||
                           (state_d == StLinkUp);
            link_up_q   <= (state_d == StLinkUp);
            fault_q     <= (state_d == StFault);
        end
    end

    assign cdr.cdr_rst_n = cdr_rst_n_q;
    assign link_up       = link_up_q;
    assign fault         = fault_q;
    assign link_drops    = drops_q;
    assign state         = state_q;

endmodule

// File: tb/tb_cdr_link_supervisor.sv
// Self-checking bench for cdr_link_supervisor (default parameters).
// A cycle-level reference model of the link rules runs alongside the DUT and is
// compared every cycle; directed sequences add fixed-value checks on durations
// and corner cases, followed by a randomized soak.
module tb_cdr_link_supervisor;

    localparam int RstCycles       = 16;
    localparam int LockTimeout     = 4096;
    localparam int SyncTimeoutBits = 1024;
    localparam int BackoffCycles   = 256;
    localparam int MaxRetries      = 4;
    localparam logic [15:0] SyncWord = 16'hA5C3;

    localparam int PIdle = 0, PCdrReset = 1, PWaitLock = 2, PHunt = 3;
    localparam int PLinkUp = 4, PBackoff = 5, PFault = 6;

    logic       clk_link = 1'b0;
    logic       rst_n, enable, clear_fault;
    logic       link_up, fault;
    logic [7:0] link_drops;
    logic [2:0] state;

    cdr_link_supervisor_if cdr ();

    cdr_link_supervisor dut (
        .clk_link    (clk_link),
        .rst_n       (rst_n),
        .enable      (enable),
        .clear_fault (clear_fault),
        .cdr         (cdr),
        .link_up     (link_up),
        .fault       (fault),
        .link_drops  (link_drops),
        .state       (state)
    );

    always #5 clk_link = ~clk_link;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int m_phase, m_cyc, m_bits, m_window, m_retries, m_drops;

    typedef struct {
        logic en;
        logic lock;
        int   rep;
        int   st;
        logic rn;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step();
        int  nxt;
        bit  fail;
        int  w;
        if (!rst_n) begin
            m_phase = PIdle; m_cyc = 0; m_bits = 0; m_window = 0; m_retries = 0; m_drops = 0;
            return;
        end
        nxt  = m_phase;
        fail = 0;
        if (!enable) begin
            nxt       = PIdle;
            m_retries = 0;
        end else begin
            case (m_phase)
                PIdle:     nxt = PCdrReset;
                PCdrReset: if (m_cyc == RstCycles - 1) nxt = PWaitLock;
                PWaitLock: begin
                    if (cdr.cdr_locked) nxt = PHunt;
                    else if (m_cyc == LockTimeout - 1) fail = 1;
                end
                PHunt: begin
                    if (!cdr.cdr_locked) begin
                        fail = 1;
                    end else if (cdr.cdr_bit_valid) begin
                        w = (m_window * 2 + int'(cdr.cdr_bit)) % 65536;
                        if (w == int'(SyncWord)) nxt = PLinkUp;
                        else if (m_bits + 1 == SyncTimeoutBits) fail = 1;
                    end
                end
                PLinkUp:   if (!cdr.cdr_locked) fail = 1;
                PBackoff:  if (m_cyc == BackoffCycles - 1) nxt = PCdrReset;
                PFault: begin
                    if (clear_fault) begin
                        nxt       = PIdle;
                        m_retries = 0;
                    end
                end
                default: ;
            endcase
            if (fail) begin
                if (m_phase == PLinkUp && m_drops < 255) m_drops++;
                m_retries++;
                nxt = (m_retries == MaxRetries) ? PFault : PBackoff;
            end
        end
        if (m_phase == PHunt && cdr.cdr_bit_valid) begin
            m_window = (m_window * 2 + int'(cdr.cdr_bit)) % 65536;
            m_bits++;
        end
        if (nxt == PHunt && m_phase != PHunt) begin
            m_window = 0;
            m_bits   = 0;
        end
        if (nxt == PLinkUp && m_phase != PLinkUp) m_retries = 0;
        m_cyc   = (nxt == m_phase) ? m_cyc + 1 : 0;
        m_phase = nxt;
    endtask

    task automatic tick();
        @(posedge clk_link);
        model_step();
        @(negedge clk_link);
        check("model state", int'(state), m_phase);
        check("model cdr_rst_n", int'(cdr.cdr_rst_n),
              (m_phase == PWaitLock || m_phase == PHunt || m_phase == PLinkUp) ? 1 : 0);
        check("model link_up", int'(link_up), (m_phase == PLinkUp) ? 1 : 0);
        check("model fault", int'(fault), (m_phase == PFault) ? 1 : 0);
        check("model link_drops", int'(link_drops), m_drops);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cdr.cdr_bit       = w[i];
            cdr.cdr_bit_valid = 1'b1;
            tick();
        end
        cdr.cdr_bit_valid = 1'b0;
    endtask

    task automatic wait_state(input int target, input int budget, input string name);
        int n = 0;
        while (int'(state) != target && n < budget) begin
            tick();
            n++;
        end
        check(name, int'(state), target);
    endtask

    task automatic count_state(input int target, input int budget, output int n);
        n = 0;
        while (int'(state) == target && n < budget) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] stream;
        logic [15:0] w16;
        logic [15:0] sw;
        logic        pending[$];
        bit          early;
        int          n;

        sw = SyncWord;
        vecs[0] = '{1'b0, 1'b0, 3,  PIdle,     1'b0};
        vecs[1] = '{1'b1, 1'b0, 1,  PCdrReset, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 15, PCdrReset, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1,  PWaitLock, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 99, PWaitLock, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1,  PHunt,     1'b1};

        rst_n = 1'b0; enable = 1'b0; clear_fault = 1'b0;
        cdr.cdr_locked = 1'b0; cdr.cdr_bit = 1'b0; cdr.cdr_bit_valid = 1'b0;
        tick();
        tick();
        check("reset state", int'(state), 0);
        check("reset cdr_rst_n", int'(cdr.cdr_rst_n), 0);
        check("reset link_up", int'(link_up), 0);
        check("reset fault", int'(fault), 0);
        check("reset link_drops", int'(link_drops), 0);
        rst_n = 1'b1;

        // Nominal bring-up up to HUNT_SYNC.
        for (int i = 0; i < 6; i++) begin
            enable         = vecs[i].en;
            cdr.cdr_locked = vecs[i].lock;
            repeat (vecs[i].rep) tick();
            check($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d cdr_rst_n", i), int'(cdr.cdr_rst_n), int'(vecs[i].rn));
        end

        // 40 random bits (no premature match) followed by the sync word.
        for (int t = 0; t < 100; t++) begin
            for (int k = 16; k < 56; k++) stream[k] = 1'($urandom_range(0, 1));
            stream[15:0] = sw;
            w16   = '0;
            early = 0;
            for (int k = 55; k >= 1; k--) begin
                w16 = {w16[14:0], stream[k]};
                if (w16 == sw) early = 1;
            end
            if (!early) break;
        end
        send_bits(64'(stream[55:1]), 55);
        check("nominal no early link_up", int'(link_up), 0);
        send_bits({63'b0, stream[0]}, 1);
        check("nominal link_up", int'(link_up), 1);
        check("nominal state", int'(state), PLinkUp);
        check("nominal fault", int'(fault), 0);

        // Three single-cycle lock drops while up.
        for (int d = 0; d < 3; d++) begin
            cdr.cdr_locked = 1'b0;
            tick();
            check("drop state", int'(state), PBackoff);
            check("drop link_up", int'(link_up), 0);
            cdr.cdr_locked = 1'b1;
            wait_state(PHunt, 600, "drop resync hunt");
            send_bits(64'(sw), 16);
            check("drop resync up", int'(state), PLinkUp);
        end
        check("drops count", int'(link_drops), 3);
        check("drops no fault", int'(fault), 0);

        // Enable drop mid-HUNT keeps link_drops.
        cdr.cdr_locked = 1'b0;
        tick();
        cdr.cdr_locked = 1'b1;
        wait_state(PHunt, 600, "en-drop hunt");
        send_bits(64'b10110, 5);
        enable = 1'b0;
        tick();
        check("en-drop state", int'(state), PIdle);
        check("en-drop cdr_rst_n", int'(cdr.cdr_rst_n), 0);
        check("en-drop link_drops", int'(link_drops), 4);
        enable = 1'b1;

        // Sync timeout on exactly the 1024th valid bit.
        wait_state(PHunt, 100, "sync-to hunt");
        cdr.cdr_bit = 1'b0;
        cdr.cdr_bit_valid = 1'b1;
        for (int i = 0; i < SyncTimeoutBits - 1; i++) tick();
        check("sync-to before", int'(state), PHunt);
        tick();
        cdr.cdr_bit_valid = 1'b0;
        check("sync-to backoff", int'(state), PBackoff);

        // Lock loss on the sync-completing bit.
        wait_state(PHunt, 600, "simul hunt");
        send_bits(64'(sw[15:1]), 15);
        cdr.cdr_bit = sw[0];
        cdr.cdr_bit_valid = 1'b1;
        cdr.cdr_locked = 1'b0;
        tick();
        cdr.cdr_bit_valid = 1'b0;
        check("simul link_up", int'(link_up), 0);
        check("simul state", int'(state), PBackoff);
        cdr.cdr_locked = 1'b1;

        // Reset mid-HUNT clears link_drops.
        wait_state(PHunt, 600, "rst hunt");
        send_bits(64'b101, 3);
        rst_n = 1'b0;
        cdr.cdr_locked = 1'b0;
        tick();
        check("rst state", int'(state), PIdle);
        check("rst cdr_rst_n", int'(cdr.cdr_rst_n), 0);
        check("rst link_drops", int'(link_drops), 0);
        rst_n = 1'b1;

        // Lock timeout x4 -> FAULT.
        wait_state(PWaitLock, 40, "lockto wait");
        for (int f = 0; f < MaxRetries; f++) begin
            count_state(PWaitLock, 5000, n);
            check("lockto wait cycles", n, LockTimeout);
            if (f < MaxRetries - 1) begin
                check("lockto backoff", int'(state), PBackoff);
                count_state(PBackoff, 1000, n);
                check("lockto backoff cycles", n, BackoffCycles);
                wait_state(PWaitLock, 40, "lockto rewait");
            end
        end
        check("fault state", int'(state), PFault);
        check("fault flag", int'(fault), 1);
        check("fault cdr_rst_n", int'(cdr.cdr_rst_n), 0);
        repeat (5) tick();
        check("fault held", int'(state), PFault);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("clear_fault idle", int'(state), PIdle);
        cdr.cdr_locked = 1'b1;
        wait_state(PHunt, 100, "rebringup hunt");
        send_bits(64'(sw), 16);
        check("rebringup up", int'(state), PLinkUp);

        // Randomized soak against the model.
        for (int c = 0; c < 20000; c++) begin
            if (enable) enable = ($urandom_range(0, 2999) != 0);
            else        enable = ($urandom_range(0, 9) == 0);
            rst_n       = ($urandom_range(0, 4999) != 0);
            clear_fault = ($urandom_range(0, 99) == 0);
            if (cdr.cdr_locked) cdr.cdr_locked = ($urandom_range(0, 399) != 0);
            else                cdr.cdr_locked = ($urandom_range(0, 14) == 0);
            cdr.cdr_bit_valid = ($urandom_range(0, 3) != 0);
            if (cdr.cdr_bit_valid) begin
                if (pending.size() == 0 && $urandom_range(0, 59) == 0) begin
                    for (int k = 15; k >= 0; k--) pending.push_back(sw[k]);
                end
                if (pending.size() != 0) cdr.cdr_bit = pending.pop_front();
                else                     cdr.cdr_bit = 1'($urandom_range(0, 1));
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
